// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - rename-path handshake bundle between dispatch/ROB and the free list
interface free_list_if #(
    parameter int FL_SIZE = 32
) ();
    localparam int CNT_W = $clog2(FL_SIZE) + 1;

    logic             dispatch_en;
    logic             branch_not_taken;
    logic             retire_valid;
    logic [6:0]       T_free_in;
    logic [6:0]       T_new_out;
    logic             free_valid;
    logic [CNT_W-1:0] free_count;
    logic             fl_empty;
`ifdef FREE_LIST_DUP_CHECK_EN
    logic             dup_error;
`endif

    // Dispatch/ROB side
    modport master (
        output dispatch_en, branch_not_taken, retire_valid, T_free_in,
`ifdef FREE_LIST_DUP_CHECK_EN
        input  dup_error,
`endif
        input  T_new_out, free_valid, free_count, fl_empty
    );

    // Free-list side
    modport slave (
        input  dispatch_en, branch_not_taken, retire_valid, T_free_in,
`ifdef FREE_LIST_DUP_CHECK_EN
        output dup_error,
`endif
        output T_new_out, free_valid, free_count, fl_empty
    );
endinterface

// File: rtl/free_list.sv
// rtl/free_list.sv - circular free physical-tag FIFO with committed head for squash; optional FREE_LIST_DUP_CHECK_EN
module free_list #(
    parameter int FL_SIZE  = 32,
    parameter int PR_COUNT = 64,
    parameter int AR_COUNT = 32
) (
    input  logic        clock,
    input  logic        reset,
    free_list_if.slave  fl
);
    localparam int IDX_W = $clog2(FL_SIZE);
    localparam int PTR_W = IDX_W + 1;
    localparam int TAG_W = $clog2(PR_COUNT);

    logic [TAG_W-1:0] entry_q [FL_SIZE];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] commit_q, commit_d;

    logic [PTR_W-1:0] count;
    logic             empty;
    logic             full;
    logic             alloc;
    logic             rel_req;
    logic             rel_ok;

    // Occupancy and the accept/drop decisions for this edge
    always_comb begin
        count   = tail_q - head_q;
        empty   = (count == '0);
        full    = (count == PTR_W'(FL_SIZE));
        alloc   = fl.dispatch_en && !empty && !fl.branch_not_taken;
        rel_req = fl.retire_valid && (fl.T_free_in != 7'h7F);
        // A full list can still accept a release when the head slot is vacated on the same edge
        rel_ok  = rel_req && (!full || alloc);
    end

    // Next-state pointers; squash rewinds head to the commit point including this edge's retire
    always_comb begin
        commit_d = fl.retire_valid ? commit_q + 1'b1 : commit_q;
        tail_d   = rel_ok ? tail_q + 1'b1 : tail_q;
        if (fl.branch_not_taken) begin
            head_d = commit_d;
        end else if (alloc) begin
            head_d = head_q + 1'b1;
        end else begin
            head_d = head_q;
        end
    end

    // Pointer registers; reset leaves the list full of the unmapped tags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= PTR_W'(FL_SIZE);
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
        end
    end

    // Tag storage; released tags are written at the tail slot
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                entry_q[i] <= TAG_W'(AR_COUNT + i);
            end
        end else if (rel_ok) begin
            entry_q[tail_q[IDX_W-1:0]] <= fl.T_free_in[TAG_W-1:0];
        end
    end

    assign fl.T_new_out  = {{(7-TAG_W){1'b0}}, entry_q[head_q[IDX_W-1:0]]};
    assign fl.free_count = count;
    assign fl.fl_empty   = empty;
    assign fl.free_valid = !empty;

`ifdef FREE_LIST_DUP_CHECK_EN
    logic             dup_q;
    logic             dup_hit;
    logic [IDX_W-1:0] dup_off;

    // A released tag matching any slot between head and tail is a double free
    always_comb begin
        dup_hit = 1'b0;
        dup_off = '0;
        for (int i = 0; i < FL_SIZE; i++) begin
            dup_off = IDX_W'(i) - head_q[IDX_W-1:0];
            if (({1'b0, dup_off} < count) && (entry_q[i] == fl.T_free_in[TAG_W-1:0])) begin
                dup_hit = 1'b1;
            end
        end
    end

    // Sticky error: double free, or a release that had to be dropped because the list was full
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dup_q <= 1'b0;
        end else if (rel_req && (dup_hit || (full && !alloc))) begin
            dup_q <= 1'b1;
        end
    end

    assign fl.dup_error = dup_q;
`endif
endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard testbench for free_list
module tb_free_list;
    logic clock;
    logic reset;
    int   checks;
    int   failures;
    logic [6:0] exp_q[$];
    logic [6:0] exp_tag;

    free_list_if #(.FL_SIZE(32)) fl ();

    free_list #(.FL_SIZE(32), .PR_COUNT(64), .AR_COUNT(32)) dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        fl.dispatch_en      = 1'b0;
        fl.branch_not_taken = 1'b0;
        fl.retire_valid     = 1'b0;
        fl.T_free_in        = 7'h7F;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Dispatch n times; each tag seen at the head is popped from the scoreboard and compared
    task automatic drain_check(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            fl.dispatch_en = 1'b1;
            exp_tag = exp_q.pop_front();
            checks++;
            if (fl.T_new_out !== exp_tag) begin
                failures++;
                $display("FAIL %s[%0d] T_new_out=%0d expected=%0d", name, i, fl.T_new_out, exp_tag);
            end
            step();
        end
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (fl.free_count !== 6'd32) begin
            failures++; $display("FAIL reset_count got=%0d exp=32", fl.free_count);
        end
        checks++;
        if (fl.fl_empty !== 1'b0) begin
            failures++; $display("FAIL reset_empty got=%0b exp=0", fl.fl_empty);
        end
        checks++;
        if (fl.free_valid !== 1'b1) begin
            failures++; $display("FAIL reset_valid got=%0b exp=1", fl.free_valid);
        end
        checks++;
        if (fl.T_new_out !== 7'd32) begin
            failures++; $display("FAIL reset_tag got=%0d exp=32", fl.T_new_out);
        end
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 32; i++) exp_q.push_back(7'(32 + i));
        drain_check(32, "drain");
        checks++;
        if (fl.free_count !== 6'd0) begin
            failures++; $display("FAIL drain_count got=%0d exp=0", fl.free_count);
        end
        checks++;
        if (fl.fl_empty !== 1'b1 || fl.free_valid !== 1'b0) begin
            failures++; $display("FAIL drain_empty empty=%0b valid=%0b exp=1/0", fl.fl_empty, fl.free_valid);
        end
        fl.dispatch_en = 1'b1;
        step();
        idle();
        checks++;
        if (fl.free_count !== 6'd0) begin
            failures++; $display("FAIL extra_alloc_count got=%0d exp=0", fl.free_count);
        end
    endtask

    // Continues from the empty list left by test_drain; allocate in the same cycle is ignored
    task automatic test_release_empty();
        fl.dispatch_en  = 1'b1;
        fl.retire_valid = 1'b1;
        fl.T_free_in    = 7'd5;
        step();
        idle();
        checks++;
        if (fl.free_valid !== 1'b1 || fl.T_new_out !== 7'd5 || fl.free_count !== 6'd1) begin
            failures++;
            $display("FAIL release_empty valid=%0b tag=%0d count=%0d exp=1/5/1",
                     fl.free_valid, fl.T_new_out, fl.free_count);
        end
    endtask

    task automatic test_squash();
        do_reset();
        fl.dispatch_en = 1'b1;
        repeat (3) step();
        idle();
        fl.retire_valid = 1'b1;
        fl.T_free_in    = 7'd3;
        step();
        idle();
        fl.branch_not_taken = 1'b1;
        fl.dispatch_en      = 1'b1;
        step();
        idle();
        checks++;
        if (fl.T_new_out !== 7'd33 || fl.free_count !== 6'd32) begin
            failures++;
            $display("FAIL squash tag=%0d count=%0d exp=33/32", fl.T_new_out, fl.free_count);
        end
        for (int i = 0; i < 31; i++) exp_q.push_back(7'(33 + i));
        exp_q.push_back(7'd3);
        drain_check(32, "squash_drain");
        checks++;
        if (fl.fl_empty !== 1'b1) begin
            failures++; $display("FAIL squash_empty got=%0b exp=1", fl.fl_empty);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fl.dispatch_en  = 1'b1;
        fl.retire_valid = 1'b1;
        fl.T_free_in    = 7'd7;
        step();
        idle();
        checks++;
        if (fl.free_count !== 6'd32 || fl.T_new_out !== 7'd33) begin
            failures++;
            $display("FAIL simul count=%0d tag=%0d exp=32/33", fl.free_count, fl.T_new_out);
        end
        for (int i = 0; i < 31; i++) exp_q.push_back(7'(33 + i));
        exp_q.push_back(7'd7);
        drain_check(32, "simul_drain");
    endtask

    task automatic test_null_retire();
        do_reset();
        fl.dispatch_en = 1'b1;
        repeat (2) step();
        idle();
        fl.retire_valid = 1'b1;
        fl.T_free_in    = 7'h7F;
        step();
        idle();
        checks++;
        if (fl.free_count !== 6'd30) begin
            failures++; $display("FAIL null_retire_count got=%0d exp=30", fl.free_count);
        end
        fl.branch_not_taken = 1'b1;
        step();
        idle();
        checks++;
        if (fl.T_new_out !== 7'd33 || fl.free_count !== 6'd31) begin
            failures++;
            $display("FAIL null_retire_commit tag=%0d count=%0d exp=33/31", fl.T_new_out, fl.free_count);
        end
    endtask

    task automatic test_full_drop();
        do_reset();
        fl.retire_valid = 1'b1;
        fl.T_free_in    = 7'd9;
        step();
        idle();
        checks++;
        if (fl.free_count !== 6'd32 || fl.T_new_out !== 7'd32) begin
            failures++;
            $display("FAIL full_drop count=%0d tag=%0d exp=32/32", fl.free_count, fl.T_new_out);
        end
        exp_q.push_back(7'd32);
        exp_q.push_back(7'd33);
        drain_check(2, "full_drop_drain");
    endtask

    task automatic test_async_reset();
        do_reset();
        fl.dispatch_en = 1'b1;
        repeat (2) step();
        idle();
        checks++;
        if (fl.free_count !== 6'd30) begin
            failures++; $display("FAIL pre_async_count got=%0d exp=30", fl.free_count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (fl.free_count !== 6'd32 || fl.T_new_out !== 7'd32 ||
            fl.fl_empty !== 1'b0 || fl.free_valid !== 1'b1) begin
            failures++;
            $display("FAIL async_reset count=%0d tag=%0d empty=%0b valid=%0b exp=32/32/0/1",
                     fl.free_count, fl.T_new_out, fl.fl_empty, fl.free_valid);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

`ifdef FREE_LIST_DUP_CHECK_EN
    task automatic test_dup();
        do_reset();
        checks++;
        if (fl.dup_error !== 1'b0) begin
            failures++; $display("FAIL dup_reset got=%0b exp=0", fl.dup_error);
        end
        fl.dispatch_en = 1'b1;
        step();
        idle();
        fl.retire_valid = 1'b1;
        fl.T_free_in    = 7'd40;
        step();
        idle();
        repeat (2) step();
        checks++;
        if (fl.dup_error !== 1'b1) begin
            failures++; $display("FAIL dup_sticky got=%0b exp=1", fl.dup_error);
        end
        do_reset();
        checks++;
        if (fl.dup_error !== 1'b0) begin
            failures++; $display("FAIL dup_clear got=%0b exp=0", fl.dup_error);
        end
    endtask
`endif

    initial begin
        clock    = 1'b0;
        reset    = 1'b1;
        checks   = 0;
        failures = 0;
        idle();
        @(negedge clock);
        test_reset();
        test_drain();
        test_release_empty();
        test_squash();
        test_back_to_back();
        test_null_retire();
        test_full_drop();
        test_async_reset();
`ifdef FREE_LIST_DUP_CHECK_EN
        test_dup();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
